// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared types and constants for the program-counter unit.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package pc_pkg;

    localparam int PC_OP_W      = 3;
    localparam int PC_DEFAULT_W = 13;

    // Encodings 5..7 are reserved and behave as HOLD.
    typedef enum logic [PC_OP_W-1:0] {
        PC_OP_INC  = 3'd0,
        PC_OP_SKIP = 3'd1,
        PC_OP_JUMP = 3'd2,
        PC_OP_CALL = 3'd3,
        PC_OP_RET  = 3'd4
    } pc_op_t;

endpackage
`default_nettype wire

// File: rtl/pc_stack.sv
`default_nettype none
// ============================================================================
// Module      : pc_stack
// Description : Return-address LIFO built on a circular buffer. WRAP_STACK
//               selects overwrite-oldest (1) or drop-when-full (0) behaviour.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module pc_stack
    import pc_pkg::*;
#(
    parameter int DATA_W      = PC_DEFAULT_W,
    parameter int STACK_DEPTH = 8,
    parameter bit WRAP_STACK  = 1'b1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push,
    input  logic                             pop,
    input  logic [DATA_W-1:0]                push_data,
    output logic [DATA_W-1:0]                top_data,
    output logic [$clog2(STACK_DEPTH+1)-1:0] count,
    output logic                             full,
    output logic                             empty
);

    localparam int c_ptr_w = $clog2(STACK_DEPTH);
    localparam int c_cnt_w = $clog2(STACK_DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(STACK_DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(STACK_DEPTH);

    logic [DATA_W-1:0]  r_mem [STACK_DEPTH];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_cnt_w-1:0] r_count;
    logic [c_ptr_w-1:0] w_rptr;
    logic [c_ptr_w-1:0] w_wnext;
    logic               w_do_push;
    logic               w_do_pop;

    // The write pointer always names the next free slot; the entry just
    // below it (circularly) is the top of stack.
    assign w_rptr  = (r_wptr == '0)     ? c_last : r_wptr - c_ptr_w'(1);
    assign w_wnext = (r_wptr == c_last) ? '0     : r_wptr + c_ptr_w'(1);

    assign full     = (r_count == c_depth);
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign top_data = r_mem[w_rptr];

    // A circular stack always moves its pointer; a saturating one refuses
    // pushes when full and pops when empty.
    assign w_do_push = push && (WRAP_STACK || !full);
    assign w_do_pop  = pop  && (WRAP_STACK || !empty);

    // Storage, pointer and occupancy update; the count saturates at both ends.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wptr] <= push_data;
            r_wptr        <= w_wnext;
            if (!full) begin
                r_count <= r_count + c_cnt_w'(1);
            end
        end else if (w_do_pop) begin
            r_wptr <= w_rptr;
            if (!empty) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Program counter with skip, absolute jump and a hardware
//               call/return stack; drives the instruction-fetch address.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module pc_unit
    import pc_pkg::*;
#(
    parameter int          PC_W        = PC_DEFAULT_W,
    parameter int          STACK_DEPTH = 8,
    parameter int unsigned RESET_VEC   = 0,
    parameter bit          WRAP_STACK  = 1'b1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             en,
    input  pc_op_t                           op,
    input  logic [PC_W-1:0]                  target,
    output logic [PC_W-1:0]                  pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
    output logic                             stack_ovf,
    output logic                             stack_unf
);

    localparam logic [PC_W-1:0] c_reset_vec = PC_W'(RESET_VEC);

    logic [PC_W-1:0] r_pc;
    logic            r_ovf;
    logic            r_unf;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_pc_skip;
    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_top;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;

    assign w_pc_inc  = r_pc + PC_W'(1);
    assign w_pc_skip = r_pc + PC_W'(2);
    assign w_push    = en && (op == PC_OP_CALL);
    assign w_pop     = en && (op == PC_OP_RET);

    pc_stack #(
        .DATA_W      (PC_W),
        .STACK_DEPTH (STACK_DEPTH),
        .WRAP_STACK  (WRAP_STACK)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .top_data  (w_top),
        .count     (sp),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Next-pc mux; reserved encodings hold the current address.
    always_comb begin
        w_pc_next = r_pc;
        case (op)
            PC_OP_INC:  w_pc_next = w_pc_inc;
            PC_OP_SKIP: w_pc_next = w_pc_skip;
            PC_OP_JUMP: w_pc_next = target;
            PC_OP_CALL: w_pc_next = target;
            PC_OP_RET:  w_pc_next = (!WRAP_STACK && w_empty) ? w_pc_inc : w_top;
            default:    w_pc_next = r_pc;
        endcase
    end

    // PC register and sticky stack error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc  <= c_reset_vec;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (en) begin
            r_pc <= w_pc_next;
            if (w_push && w_full) begin
                r_ovf <= 1'b1;
            end
            if (w_pop && w_empty) begin
                r_unf <= 1'b1;
            end
        end
    end

    assign pc        = r_pc;
    assign stack_ovf = r_ovf;
    assign stack_unf = r_unf;

endmodule
`default_nettype wire

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the processor core; successor to the fixed-width counter. Adds a configurable address width, reset vector, skip, absolute jump, and a hardware call/return stack with configurable depth and overflow policy. It drives the instruction-fetch address. Decode supplies one operation per enabled cycle.

## Interface
- `PC_W`, 13, program counter width in bits.
- `STACK_DEPTH`, 8, number of return-address entries; minimum 2.
- `RESET_VEC`, 0, value loaded into `pc` on reset; truncated to `PC_W` bits.
- `WRAP_STACK`, 1:
  - 1: circular stack; a push when full overwrites the oldest entry.
  - 0: saturating stack; a push when full is dropped.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `en`  in  1  advance enable; 0 holds all state.
- `op`  in  3  operation, type `pc_op_t`.
- `target`  in  `PC_W`  destination address for JUMP and CALL.
- `pc`  out  `PC_W`  current fetch address (registered).
- `sp`  out  `$clog2(STACK_DEPTH+1)`  number of valid stack entries, 0..`STACK_DEPTH`.
- `stack_ovf`  out  1  sticky flag: a CALL was issued while the stack was full.
- `stack_unf`  out  1  sticky flag: a RET was issued while the stack was empty.

## Operation
- Encodings of `op`:
  - INC = 0: `pc <= pc+1`.
  - SKIP = 1: `pc <= pc+2`.
  - JUMP = 2: `pc <= target`.
  - CALL = 3: push `pc+1`, then `pc <= target`.
  - RET = 4: pop the top entry into `pc`.
  - 5..7 are reserved and act as HOLD (no state change, no flag change).
- All `pc` arithmetic is modulo 2^`PC_W`. Examples: 0x1FFF+1 = 0x0000; 0x1FFE+2 = 0x0000.
- CALL when `sp == STACK_DEPTH`: the jump is always taken and `stack_ovf` is set.
  - `WRAP_STACK=1`: the oldest entry is overwritten and `sp` stays at `STACK_DEPTH`.
  - `WRAP_STACK=0`: the push is discarded and the stack is unchanged.
- RET when `sp == 0`: `stack_unf` is set.
  - `WRAP_STACK=1`: `pc` loads the entry at the circular read pointer (stale data) and `sp` stays 0.
  - `WRAP_STACK=0`: `pc <= pc+1` and the stack is unchanged.
- RET after circular overflow pops newest-first. Only the most recent `STACK_DEPTH` return addresses are recoverable.
- `stack_ovf` and `stack_unf` are cleared only by reset.
- There is no state machine beyond the stack pointer. `sp` saturates as described above and never wraps below 0 or above `STACK_DEPTH`.

## Timing
- `op` and `target` are sampled on the rising edge of `clk` when `en=1`. The new `pc` and `sp` are visible immediately after that same edge. Latency is 1 cycle.
- Each of these is one cycle: push+jump, pop+load, and flag set. There is no bubble and no back-to-back hazard, so CALL followed directly by RET returns to the CALL address + 1.
- With `en=0`, `pc`, `sp`, the stack and the flags hold, and `op` is ignored.
- `reset=0` at a rising edge overrides `en` and `op`. After that edge:
  - `pc = RESET_VEC`, `sp = 0`
  - `stack_ovf = 0`, `stack_unf = 0`
  - all stack entries are 0
- Reset asserted during a call chain discards all return addresses.
- Outputs are driven directly from registers; there is no combinational path from `op` to `pc`.

## Structure
- Package `pc_pkg` holds:
  - the `pc_op_t` enum (3 bits, encodings above);
  - the constants `PC_OP_W=3` and `PC_DEFAULT_W=13`.
- Sub-module `pc_stack` holds the LIFO storage:
  - inputs: `push`, `pop`, `push_data`;
  - outputs: `top_data`, `count`, `full`, `empty`;
  - the `WRAP_STACK` policy.
- `pc_unit` contains the `pc` register, the next-pc mux and the sticky flags.

## Test plan
1. Reset vector and increment: with `RESET_VEC=0x100`, release reset, then 5 INC with `en=1` → `pc` steps 0x101..0x105 and `sp=0`.
2. Wrap-around: JUMP 0x1FFF then INC → `pc=0x0000`. JUMP 0x1FFE then SKIP → `pc=0x0000`.
3. Call/return: at `pc=0x010`, CALL 0x050 → `pc=0x050`, `sp=1`. Next cycle RET → `pc=0x011`, `sp=0`, no flags set.
4. Overflow: depth 8, 9 nested CALLs issued from `pc=0x001..0x009`.
   - `WRAP_STACK=1`: `stack_ovf=1`, `sp=8`; 8 RETs yield 0x00A, 0x009, …, 0x003.
   - `WRAP_STACK=0`: 8 RETs yield 0x009, 0x008, …, 0x002.
5. Underflow: with `WRAP_STACK=0`, RET at `sp=0` from `pc=0x020` → `pc=0x021` and `stack_unf=1`. The flag stays 1 through 10 further INCs and clears only on reset.
6. Enable and reset priority: `en=0` with CALL 0x300 → `pc` and `sp` unchanged. Then assert `reset=0` with `en=0` → `pc=RESET_VEC`, `sp=0` and both flags 0.
